sram_responder: RTL
===================

Name: sram_responder

Overview:
- Synthesizable memory-side responder for the SRAM bench interface (addr/din/we/valid_tx in, dout out).
- Executes write and read requests against an internal array.
- Returns read data through a configurable-latency pipeline with a valid strobe.
- Provides a post-reset clear sequence, range checking and transaction counters, so the bench has a cycle-accurate DUT/reference end for the SRAM protocol.

Parameters:
- DEPTH, 1024, number of 256-bit words implemented; legal addresses 0..DEPTH-1, DEPTH <= 32768.
- READ_LATENCY, 1, posedges from read acceptance to dout_valid; legal 1..4.
- INIT_CLEAR, 1, 1 = zero the whole array after reset before accepting requests; 0 = skip the clear.

Ports:
- clk  input  1  clock; all logic is posedge.
- rstn  input  1  asynchronous, active-low reset.
- valid_tx  input  1  request strobe; sampled at posedge.
- we  input  1  1 = write, 0 = read; qualified by valid_tx.
- addr  input  15  word address.
- din  input  256  write data.
- rdy  output  1  responder accepts requests.
- dout  output  256  read data.
- dout_valid  output  1  one-cycle strobe; dout holds read data.
- err  output  1  one-cycle error strobe.
- wr_count  output  16  accepted in-range writes, wrapping.
- rd_count  output  16  accepted in-range reads, wrapping.

Behaviour:
- Reset (asynchronous, rstn=0):
  - Outputs: rdy=0, dout=0, dout_valid=0, err=0, wr_count=0, rd_count=0.
  - Read pipeline is flushed.
  - Internal clr_ptr=0.
  - State = INIT if INIT_CLEAR=1, else RUN. Array contents are not touched asynchronously.
- FSM has two states, INIT and RUN:
  - INIT: each posedge writes 0 to mem[clr_ptr] and increments clr_ptr. On the edge clearing DEPTH-1, go to RUN. rdy stays 0 throughout INIT.
  - RUN: rdy=1 (registered; first high in the cycle after the INIT→RUN edge, or after the first posedge following rstn release if INIT_CLEAR=0).
  - No other transitions. Only rstn returns the FSM to INIT.
- Acceptance: a request is accepted at a posedge with valid_tx=1 and rdy=1. There is no backpressure in RUN; one request can be accepted per cycle.
- Write, in range (we=1, addr<DEPTH): mem[addr]<=din at the accepting edge; wr_count++ at the same edge.
- Read, in range (we=0, addr<DEPTH):
  - Reads the array at the accepting edge and sees all writes accepted on earlier edges. A read in the cycle after a write to the same address returns the new data.
  - dout/dout_valid are updated on the READ_LATENCY-th posedge counted from the accepting edge (latency 1 = visible right after the accepting edge).
  - rd_count++ at the accepting edge.
- Back-to-back reads: the pipeline is fully pipelined. N consecutive reads give N consecutive dout_valid cycles, in order.
- dout holds its last value while dout_valid=0.
- Out of range (addr>=DEPTH):
  - Write: dropped; err=1 for one cycle after the accepting edge.
  - Read: dout=0 and dout_valid=1 at normal latency; err=1 aligned with that dout_valid.
  - Counters are not incremented.
- Request while rdy=0: ignored, with no array or pipeline effect and no counter change; err=1 the following cycle.
- valid_tx=0: we/addr/din are ignored, including X/Z.
- Counters wrap 0xFFFF→0x0000.
- Reset asserted mid-operation: in-flight reads are discarded (no dout_valid). A clear in progress restarts from address 0.

Test Plan:
- INIT_CLEAR=1, DEPTH=16: release rstn, then read addr 5 → rdy low exactly 16 cycles then high; read returns dout=0, dout_valid 1 cycle after acceptance, err=0.
- Write addr 3 = 256'hA5..A5, next cycle read addr 3 → dout=A5..A5; wr_count=1, rd_count=1.
- READ_LATENCY=3: write 4 distinct words to addr 0..3, then 4 back-to-back reads → 4 consecutive dout_valid cycles starting 3 edges after first acceptance, data in order.
- DEPTH=1024: write addr 1024 → err pulse next cycle, wr_count unchanged. Read addr 2000 → dout=0, dout_valid=1, err=1 same cycle.
- Request during INIT → ignored, err one cycle later. Assert rstn mid-read with READ_LATENCY=4 → no dout_valid; dout=0 and clear restarts.
- 65537 in-range writes → wr_count=1 after wrap.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the SRAM bench interface.
// Executes writes/reads on an internal array and returns read data through
// a READ_LATENCY-deep pipeline. An optional post-reset clear zeroes the array.
// Ports:
//   clk, rstn              clock, async active-low reset
//   valid_tx, we, addr     request strobe, 1=write/0=read, word address
//   din                    write data
//   rdy                    high once the responder accepts requests
//   dout, dout_valid       read data and its one-cycle strobe
//   err                    one-cycle error strobe
//   wr_count, rd_count     accepted in-range writes / reads, wrapping
module sram_responder #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter bit INIT_CLEAR   = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid_tx,
    input  logic         we,
    input  logic [14:0]  addr,
    input  logic [255:0] din,
    output logic         rdy,
    output logic [255:0] dout,
    output logic         dout_valid,
    output logic         err,
    output logic [15:0]  wr_count,
    output logic [15:0]  rd_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [AW-1:0]     clr_ptr;
    logic [255:0]      mem [DEPTH];

    logic              acc;
    logic              in_range;
    logic              rd_acc;
    logic              wr_ok;
    logic [255:0]      rd_data;
    logic              err_q;

    // Read pipeline: stage data only moves with its valid bit, so the last
    // stage holds the previous read data while no new read arrives.
    logic [READ_LATENCY-1:0] pv;
    logic [READ_LATENCY-1:0] pe;
    logic [255:0]            pd [READ_LATENCY];

    assign acc      = valid_tx & rdy;
    assign in_range = {17'd0, addr} < 32'(DEPTH);
    assign rd_acc   = acc & ~we;
    assign wr_ok    = acc & we & in_range;
    assign rd_data  = in_range ? mem[addr[AW-1:0]] : '0;

    // Array has no reset; the clear sequence runs only while out of reset.
    always_ff @(posedge clk) begin
        if (rstn && state == INIT) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            mem[addr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= INIT_CLEAR ? INIT : RUN;
            clr_ptr  <= '0;
            rdy      <= 1'b0;
            err_q    <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
            pv       <= '0;
            pe       <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pd[k] <= '0;
            end
        end else begin
            // rdy rises together with the INIT->RUN transition edge
            rdy <= (state == RUN) || (clr_ptr == LAST);
            if (state == INIT) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == LAST) begin
                    state <= RUN;
                end
            end

            err_q <= (valid_tx & ~rdy) | (acc & we & ~in_range);

            if (wr_ok) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rd_acc && in_range) begin
                rd_count <= rd_count + 16'd1;
            end

            pv[0] <= rd_acc;
            pe[0] <= rd_acc & ~in_range;
            if (rd_acc) begin
                pd[0] <= rd_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                pe[k] <= pe[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign dout_valid = pv[READ_LATENCY-1];
    assign dout       = pd[READ_LATENCY-1];
    // Out-of-range reads flag err in the same cycle as their dout_valid.
    assign err        = err_q | (pv[READ_LATENCY-1] & pe[READ_LATENCY-1]);

endmodule
